// File: rtl/ubsoc_dbg_pkg.sv
// ---------------------------------------------------------------------------
// ubsoc_dbg_pkg
// Shared definitions for the SoC debug-harness monitors.
//   - uart_state_e : receiver FSM state encoding (3 bits)
//   - UART_BITS    : data bits per UART frame
//   - CLK_DIV_DEFAULT : clk cycles per bit for 12 MHz clock / 115200 baud
// ---------------------------------------------------------------------------
package ubsoc_dbg_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } uart_state_e;

    localparam int UART_BITS = 8;

    // 12_000_000 / 115_200 = 104.17, rounded down
    localparam int CLK_DIV_DEFAULT = 104;

endpackage : ubsoc_dbg_pkg

// File: rtl/ubsoc_sync_fifo.sv
// ---------------------------------------------------------------------------
// ubsoc_sync_fifo
// Single-clock circular FIFO with a first-word-fall-through head.
//   clk_i    : clock
//   resetn_i : asynchronous active-low reset (empties the FIFO)
//   push     : write request; accepted when not full, or when full and a
//              pop happens in the same cycle (writes into the freed slot)
//   din      : write data
//   pop      : read request; ignored while empty
//   dout     : head entry, zero while empty
//   count    : occupancy 0..DEPTH
//   full     : count == DEPTH
//   empty    : count == 0
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module ubsoc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       resetn_i,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);

    assign w_do_pop  = pop & ~empty;
    // When full, a simultaneous pop frees the head slot, which is exactly
    // where the write pointer sits, so the push can land there.
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; the head is masked while empty instead.
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    assign dout  = empty ? '0 : r_mem[r_rd_ptr];
    assign count = r_count;

endmodule : ubsoc_sync_fifo

// File: rtl/ubsoc_uart_monitor.sv
// ---------------------------------------------------------------------------
// ubsoc_uart_monitor
// Watches a UART TX line (8N1), buffers received bytes in a FIFO and flags
// framing errors, FIFO overflow and occurrences of a match byte.
//   clk_i       : system clock
//   resetn_i    : asynchronous active-low reset
//   rx_i        : serial line, asynchronous, idle high
//   rd_en_i     : pop request
//   rd_data_o   : head-of-FIFO byte, valid while rd_valid_o = 1
//   rd_valid_o  : FIFO not empty
//   count_o     : FIFO occupancy
//   match_o     : one-cycle pulse when an accepted byte equals MATCH_BYTE
//   frame_err_o : sticky, stop bit sampled low
//   overflow_o  : sticky, byte dropped because the FIFO was full
//   clr_i       : synchronous clear of both sticky flags (a set wins)
//   dbg_state_o : receiver FSM state
//
// Read handshake: a byte is consumed on a clock edge where rd_valid_o and
// rd_en_i are both high; rd_en_i without rd_valid_o has no effect, and
// rd_data_o is held stable until it is consumed.
// ---------------------------------------------------------------------------
module ubsoc_uart_monitor
    import ubsoc_dbg_pkg::*;
#(
    parameter int         CLK_DIV    = CLK_DIV_DEFAULT,
    parameter int         FIFO_DEPTH = 16,
    parameter logic [7:0] MATCH_BYTE = 8'h0A
) (
    input  logic                            clk_i,
    input  logic                            resetn_i,
    input  logic                            rx_i,
    input  logic                            rd_en_i,
    output logic [7:0]                      rd_data_o,
    output logic                            rd_valid_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o,
    output logic                            match_o,
    output logic                            frame_err_o,
    output logic                            overflow_o,
    input  logic                            clr_i,
    output logic [2:0]                      dbg_state_o
);

    localparam int TMR_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);
    localparam int IDX_W = $clog2(UART_BITS);

    // ---------------- input synchroniser and edge detect -------------------
    logic r_sync1;
    logic r_sync2;
    logic r_rx_prev;
    logic w_rx_s;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rx_i;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_rx_s = r_sync2;

    // ---------------- receiver FSM -----------------------------------------
    uart_state_e r_state;
    uart_state_e w_state_next;

    logic [TMR_W-1:0]     r_timer;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [UART_BITS-1:0] r_shift;

    logic w_half_tick;
    logic w_bit_tick;
    logic w_last_bit;
    logic w_sample_data;
    logic w_push_req;
    logic w_frame_err_set;
    logic w_timer_reload;

    assign w_half_tick = (r_timer == TMR_W'(CLK_DIV/2 - 1));
    assign w_bit_tick  = (r_timer == TMR_W'(CLK_DIV - 1));
    assign w_last_bit  = (r_bit_idx == IDX_W'(UART_BITS - 1));

    // State register
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_rx_prev && !w_rx_s) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                // Line back high at mid-start-bit: a glitch, not a frame.
                if (w_half_tick) begin
                    w_state_next = w_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_tick && w_last_bit) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                // Leave at mid-stop-bit so a back-to-back start edge is seen.
                if (w_bit_tick) begin
                    w_state_next = w_rx_s ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                // Hold off until the line is released so a stuck-low line
                // cannot generate phantom frames.
                if (w_rx_s) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output / control logic
    always_comb begin
        w_sample_data   = 1'b0;
        w_push_req      = 1'b0;
        w_frame_err_set = 1'b0;
        case (r_state)
            S_DATA: w_sample_data = w_bit_tick;
            S_STOP: begin
                w_push_req      = w_bit_tick &  w_rx_s;
                w_frame_err_set = w_bit_tick & ~w_rx_s;
            end
            default: ;
        endcase
        // The bit timer restarts on every state entry and after every
        // data-bit sample so each sample lands CLK_DIV after the previous.
        w_timer_reload = (w_state_next != r_state) | w_sample_data;
    end

    // Bit timer, bit index and shift register
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if (w_timer_reload || w_bit_tick) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TMR_W'(1);
            end

            if (r_state != S_DATA) begin
                r_bit_idx <= '0;
            end else if (w_sample_data) begin
                r_bit_idx <= r_bit_idx + IDX_W'(1);
            end

            // LSB arrives first, so shift in from the top.
            if (w_sample_data) begin
                r_shift <= {w_rx_s, r_shift[UART_BITS-1:1]};
            end
        end
    end

    assign dbg_state_o = r_state;

    // ---------------- FIFO --------------------------------------------------
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_pop;
    logic             w_accept;
    logic             w_overflow_set;
    logic [CNT_W-1:0] w_count;
    logic [7:0]       w_fifo_dout;

    assign w_pop          = rd_en_i & ~w_fifo_empty;
    assign w_accept       = w_push_req & (~w_fifo_full | w_pop);
    assign w_overflow_set = w_push_req & w_fifo_full & ~w_pop;

    ubsoc_sync_fifo #(
        .WIDTH (UART_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .push     (w_push_req),
        .din      (r_shift),
        .pop      (w_pop),
        .dout     (w_fifo_dout),
        .count    (w_count),
        .full     (w_fifo_full),
        .empty    (w_fifo_empty)
    );

    assign rd_data_o  = w_fifo_dout;
    assign rd_valid_o = ~w_fifo_empty;
    assign count_o    = w_count;

    // ---------------- match pulse and sticky flags --------------------------
    logic r_match;
    logic r_frame_err;
    logic r_overflow;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_match     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            // Registered so the pulse lines up with the byte appearing.
            r_match <= w_accept & (r_shift == MATCH_BYTE);

            if (w_frame_err_set) begin
                r_frame_err <= 1'b1;
            end else if (clr_i) begin
                r_frame_err <= 1'b0;
            end

            if (w_overflow_set) begin
                r_overflow <= 1'b1;
            end else if (clr_i) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign match_o     = r_match;
    assign frame_err_o = r_frame_err;
    assign overflow_o  = r_overflow;

endmodule : ubsoc_uart_monitor

// File: tb/tb_ubsoc_uart_monitor.sv
// ---------------------------------------------------------------------------
// tb_ubsoc_uart_monitor
// Directed bench for ubsoc_uart_monitor with CLK_DIV=16, FIFO_DEPTH=4.
// ---------------------------------------------------------------------------
module tb_ubsoc_uart_monitor;
    import ubsoc_dbg_pkg::*;

    localparam int CLK_DIV    = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W      = $clog2(FIFO_DEPTH+1);

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             resetn_i;
    logic             rx_i;
    logic             rd_en_i;
    logic             clr_i;
    logic [7:0]       rd_data_o;
    logic             rd_valid_o;
    logic [CNT_W-1:0] count_o;
    logic             match_o;
    logic             frame_err_o;
    logic             overflow_o;
    logic [2:0]       dbg_state_o;

    always #5 clk = ~clk;

    ubsoc_uart_monitor #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH),
        .MATCH_BYTE (8'h0A)
    ) dut (
        .clk_i       (clk),
        .resetn_i    (resetn_i),
        .rx_i        (rx_i),
        .rd_en_i     (rd_en_i),
        .rd_data_o   (rd_data_o),
        .rd_valid_o  (rd_valid_o),
        .count_o     (count_o),
        .match_o     (match_o),
        .frame_err_o (frame_err_o),
        .overflow_o  (overflow_o),
        .clr_i       (clr_i),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int         n_total = 0;
    int         n_bad   = 0;
    int         match_cnt = 0;

    always @(negedge clk) begin
        if (match_o === 1'b1) match_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_bit(input logic b, input int n_bits);
        rx_i = b;
        repeat (n_bits * CLK_DIV) @(negedge clk);
    endtask

    // stop_low_bits > 0 holds the stop bit low that many bit times first.
    task automatic send_frame(input logic [7:0] b, input int stop_low_bits);
        drive_bit(1'b0, 1);
        for (int i = 0; i < 8; i++) drive_bit(b[i], 1);
        if (stop_low_bits > 0) drive_bit(1'b0, stop_low_bits);
        drive_bit(1'b1, 1);
    endtask

    task automatic pop_expect(input string tag);
        logic [7:0] e;
        e = 8'h00;
        @(negedge clk);
        check({tag, "_valid"}, rd_valid_o, 1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        check({tag, "_data"}, rd_data_o, e);
        rd_en_i = 1'b1;
        @(negedge clk);
        rd_en_i = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
    endtask

    // Returns in the first cycle of STOP (bit timer = 0), bounded.
    task automatic wait_stop_entry();
        int k;
        k = 0;
        @(negedge clk);
        while (dbg_state_o != S_STOP && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("stop_seen", dbg_state_o, S_STOP);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        resetn_i = 1'b0;
        rx_i     = 1'b1;
        rd_en_i  = 1'b0;
        clr_i    = 1'b0;
        repeat (5) @(negedge clk);

        // Reset state
        check("rst_valid", rd_valid_o, 0);
        check("rst_data", rd_data_o, 0);
        check("rst_count", count_o, 0);
        check("rst_match", match_o, 0);
        check("rst_ferr", frame_err_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_state", dbg_state_o, S_IDLE);
        resetn_i = 1'b1;
        repeat (5) @(negedge clk);

        // T1: single 0x55, exact latency at mid-stop
        exp_q.push_back(8'h55);
        fork
            send_frame(8'h55, 0);
            begin
                wait_stop_entry();
                repeat (CLK_DIV-1) @(negedge clk);
                check("t1_pre_valid", rd_valid_o, 0);
                check("t1_pre_count", count_o, 0);
                @(negedge clk);
                check("t1_valid", rd_valid_o, 1);
                check("t1_data", rd_data_o, 8'h55);
                check("t1_count", count_o, 1);
            end
        join
        repeat (4) @(negedge clk);
        check("t1_match", match_cnt, 0);
        check("t1_ferr", frame_err_o, 0);
        check("t1_ovf", overflow_o, 0);
        pop_expect("t1_pop");
        check("t1_empty", count_o, 0);

        // T2: 0x0A and 0x41 back-to-back, single match pulse
        match_cnt = 0;
        exp_q.push_back(8'h0A);
        exp_q.push_back(8'h41);
        send_frame(8'h0A, 0);
        send_frame(8'h41, 0);
        repeat (4) @(negedge clk);
        check("t2_count", count_o, 2);
        check("t2_match", match_cnt, 1);
        pop_expect("t2_pop0");
        pop_expect("t2_pop1");
        check("t2_count_end", count_o, 0);

        // T3: framing error with long low stop, then a good byte
        send_frame(8'h12, 3);
        check("t3_ferr_set", frame_err_o, 1);
        check("t3_no_push", count_o, 0);
        exp_q.push_back(8'h34);
        send_frame(8'h34, 0);
        repeat (4) @(negedge clk);
        check("t3_count", count_o, 1);
        pop_expect("t3_pop");
        check("t3_ferr_held", frame_err_o, 1);
        pulse_clr();
        check("t3_ferr_clr", frame_err_o, 0);

        // T4: five bytes into a four-deep FIFO
        for (int i = 1; i <= 5; i++) begin
            if (i <= FIFO_DEPTH) exp_q.push_back(8'(i));
            send_frame(8'(i), 0);
        end
        repeat (4) @(negedge clk);
        check("t4_count", count_o, 4);
        check("t4_ovf", overflow_o, 1);
        for (int i = 0; i < 4; i++) pop_expect("t4_pop");
        check("t4_count_end", count_o, 0);
        pulse_clr();
        check("t4_ovf_clr", overflow_o, 0);

        // T5: fifth byte pushed in the same cycle as a pop
        for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 0);
        check("t5_full", count_o, 4);
        fork
            send_frame(8'h05, 0);
            begin
                logic [7:0] e;
                wait_stop_entry();
                repeat (CLK_DIV-1) @(negedge clk);
                e = exp_q.pop_front();
                check("t5_head", rd_data_o, e);
                rd_en_i = 1'b1;
                @(negedge clk);
                rd_en_i = 1'b0;
                check("t5_count_same", count_o, 4);
            end
        join
        repeat (4) @(negedge clk);
        check("t5_count", count_o, 4);
        check("t5_ovf", overflow_o, 0);
        for (int i = 0; i < 4; i++) pop_expect("t5_pop");
        check("t5_count_end", count_o, 0);

        // T6: short glitch on the line
        @(negedge clk);
        rx_i = 1'b0;
        repeat (4) @(negedge clk);
        rx_i = 1'b1;
        repeat (3 * CLK_DIV) @(negedge clk);
        check("t6_count", count_o, 0);
        check("t6_valid", rd_valid_o, 0);
        check("t6_ferr", frame_err_o, 0);
        check("t6_ovf", overflow_o, 0);
        check("t6_state", dbg_state_o, S_IDLE);

        // T7: reset during data bit 3 of 0x99, then 0x7E
        drive_bit(1'b0, 1);
        drive_bit(1'b1, 1);
        drive_bit(1'b0, 1);
        drive_bit(1'b0, 1);
        rx_i = 1'b1;
        repeat (CLK_DIV/2) @(negedge clk);
        check("t7_in_data", dbg_state_o, S_DATA);
        resetn_i = 1'b0;
        repeat (4) @(negedge clk);
        check("t7_rst_state", dbg_state_o, S_IDLE);
        check("t7_rst_count", count_o, 0);
        resetn_i = 1'b1;
        repeat (2 * CLK_DIV) @(negedge clk);
        check("t7_no_partial", count_o, 0);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 0);
        repeat (4) @(negedge clk);
        check("t7_count", count_o, 1);
        pop_expect("t7_pop");
        check("t7_count_end", count_o, 0);
        check("t7_ferr", frame_err_o, 0);
        check("t7_q_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_ubsoc_uart_monitor
